// File: rtl/feature_cache_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// feature_cache_pingpong_ctrl
//
// This block loads the feature cache as two ping-pong banks. It accepts feature
// words from the upstream stream and writes them into the bank being filled.
// When every word of a batch has been written, the bank is handed to the
// classifier read side. The reader can consume one bank while the other bank
// is being filled. Banks are always delivered in fill order.
//
// Parameters:
//   ADDR_WIDTH  address bits per bank (bank depth = 2^ADDR_WIDTH words)
//   WORD_SIZE   feature word width
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   enable       level input; allows new batches to start
//   batch_len    words per batch; 0 or a value above 2^ADDR_WIDTH means full depth
//   data         upstream feature word
//   data_ready   upstream word valid
//   data_wanted  controller accepts a word this cycle (driven from state only)
//   we           cache write enable (one cycle after a transfer)
//   waddr        cache write address, {bank, offset}
//   wdata        cache write data
//   rd_valid     a full bank is available to the reader
//   rd_bank      bank the reader must use
//   rd_release   pulse; the reader has finished with rd_bank
//   busy         FSM is not in IDLE
//   stall_count  saturating count of cycles with data_ready high and
//                data_wanted low
//
// Build option:
//   FEATURE_CACHE_STALL_CNT_EN  when defined, builds the stall counter.
//                               Otherwise stall_count is tied to zero.
// -----------------------------------------------------------------------------
module feature_cache_pingpong_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [ADDR_WIDTH:0]   batch_len,
  input  logic [WORD_SIZE-1:0]  data,
  input  logic                  data_ready,
  output logic                  data_wanted,
  output logic                  we,
  output logic [ADDR_WIDTH:0]   waddr,
  output logic [WORD_SIZE-1:0]  wdata,
  output logic                  rd_valid,
  output logic                  rd_bank,
  input  logic                  rd_release,
  output logic                  busy,
  output logic [15:0]           stall_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_BANK
  } state_t;

  state_t                state;
  logic                  fill_bank;
  logic                  rd_ptr;
  logic [1:0]            bank_full;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] last_off;
  logic                  pend_full;
  logic                  pend_bank;

  logic                  xfer;
  logic                  last_xfer;
  logic                  rel_ok;
  logic                  fill_taken;
  logic                  next_taken;
  logic [ADDR_WIDTH:0]   len_m1;
  logic [ADDR_WIDTH-1:0] len_last;

  assign xfer      = data_ready && data_wanted;
  assign last_xfer = xfer && (offset == last_off);

  assign rd_valid = bank_full[rd_ptr];
  assign rd_bank  = rd_ptr;
  assign rel_ok   = rd_release && rd_valid;

  // The FULL flag of a completed bank only lands one cycle after its last
  // transfer, when the final write is on the port. A bank counts as occupied
  // from its last transfer onward. This keeps back-to-back short batches from
  // refilling a bank whose flag is still in flight.
  assign fill_taken = bank_full[fill_bank] || (pend_full && (pend_bank == fill_bank));
  assign next_taken = bank_full[~fill_bank] || (pend_full && (pend_bank == ~fill_bank));

  // Clamp batch_len to the last valid offset. Zero or an oversize length
  // selects the full bank depth. A length of exactly DEPTH wraps to all ones,
  // which gives the same result.
  always_comb begin
    len_m1   = batch_len - 1'b1;
    len_last = len_m1[ADDR_WIDTH-1:0];
    if ((batch_len == '0) || (batch_len > DEPTH)) begin
      len_last = '1;
    end
  end

  // Sequencing FSM. It decides when words are accepted and which bank is
  // being filled. data_wanted and busy are registered with the state, so they
  // never depend combinationally on data_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      data_wanted <= 1'b0;
      busy        <= 1'b0;
      fill_bank   <= 1'b0;
      offset      <= '0;
      last_off    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_taken) begin
            state       <= WAIT_BANK;
            data_wanted <= 1'b0;
            busy        <= 1'b1;
          end else if (enable) begin
            state       <= FILL;
            data_wanted <= 1'b1;
            busy        <= 1'b1;
            offset      <= '0;
            last_off    <= len_last;
          end
        end
        FILL: begin
          if (xfer) begin
            if (offset == last_off) begin
              fill_bank <= ~fill_bank;
              offset    <= '0;
              if (!enable) begin
                state       <= IDLE;
                data_wanted <= 1'b0;
                busy        <= 1'b0;
              end else if (next_taken) begin
                state       <= WAIT_BANK;
                data_wanted <= 1'b0;
              end else begin
                last_off <= len_last;
              end
            end else begin
              offset <= offset + ADDR_WIDTH'(1);
            end
          end
        end
        WAIT_BANK: begin
          if (!fill_taken) begin
            if (enable) begin
              state       <= FILL;
              data_wanted <= 1'b1;
              offset      <= '0;
              last_off    <= len_last;
            end else begin
              state       <= IDLE;
              data_wanted <= 1'b0;
              busy        <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          data_wanted <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Write port. It is one cycle behind the transfer. waddr and wdata keep
  // their last values between writes. A completion marker follows the final
  // write, so the bank flag is set in the same cycle the write is issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      pend_full <= 1'b0;
      pend_bank <= 1'b0;
    end else begin
      we        <= xfer;
      pend_full <= last_xfer;
      if (xfer) begin
        waddr     <= {fill_bank, offset};
        wdata     <= data;
        pend_bank <= fill_bank;
      end
    end
  end

  // Bank ownership flags and the reader pointer. A completion and a release
  // can never target the same bank in one cycle. The released bank is FULL,
  // and the completing bank is still EMPTY until this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank_full <= 2'b00;
      rd_ptr    <= 1'b0;
    end else begin
      if (pend_full) begin
        bank_full[pend_bank] <= 1'b1;
      end
      if (rel_ok) begin
        bank_full[rd_ptr] <= 1'b0;
        rd_ptr            <= ~rd_ptr;
      end
    end
  end

`ifdef FEATURE_CACHE_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts cycles where upstream has a word but the controller is not taking
  // it. The count saturates at all ones and clears only on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (data_ready && !data_wanted && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: doc/feature_cache_pingpong_ctrl.md
Name: feature_cache_pingpong_ctrl

Overview:
- Sequences loading of the feature cache as two ping-pong banks: accepts feature words from the upstream stream, drives the cache write port, and hands full banks to the classifier read side.
- Sits between the feature stream source and the feature cache write port.
- Lets the classifier read one bank while the other bank is being filled.
- A bank is exposed to the read side only when its whole batch has been written.

Parameters:
ADDR_WIDTH, 10, address bits per bank; bank depth is 2^ADDR_WIDTH words
WORD_SIZE, 32, feature word width

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  level; allows new batches to start
batch_len  input  ADDR_WIDTH+1  words per batch; sampled at batch start
data  input  WORD_SIZE  upstream feature word
data_ready  input  1  upstream word valid
data_wanted  output  1  controller accepts a word this cycle
we  output  1  cache write enable
waddr  output  ADDR_WIDTH+1  cache write address, {bank, offset}
wdata  output  WORD_SIZE  cache write data
rd_valid  output  1  a full bank is available to the reader
rd_bank  output  1  bank the reader must use
rd_release  input  1  pulse; reader finished with rd_bank
busy  output  1  FSM not in IDLE
stall_count  output  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0; both banks EMPTY; fill bank = 0; read pointer = 0; FSM = IDLE.
- Transfer rule: a word transfers when data_ready && data_wanted. data_wanted is registered-state driven only; it never depends combinationally on data_ready.
- Write latency is 1 cycle. In the cycle after a transfer: we = 1, waddr = {fill_bank, offset}, wdata = the captured word. Otherwise we = 0, and waddr/wdata hold their last values.
- Batch length: effective length L = batch_len, clamped so that 0 and any value > 2^ADDR_WIDTH become 2^ADDR_WIDTH. L is latched on entry to FILL.
- FSM IDLE: data_wanted = 0. If enable = 1 and fill_bank is EMPTY, go to FILL with offset = 0. If fill_bank is not EMPTY, go to WAIT_BANK.
- FSM FILL: data_wanted = 1. offset increments per transfer. On the transfer with offset == L-1:
  - mark fill_bank FULL and toggle fill_bank;
  - if enable = 0, go to IDLE;
  - else if the new fill_bank is FULL, go to WAIT_BANK;
  - else stay in FILL with offset = 0 and a fresh L latched.
- FSM WAIT_BANK: data_wanted = 0. When fill_bank becomes EMPTY: go to FILL if enable = 1, otherwise IDLE.
- Enable deassertion mid-batch does not abort the batch; it completes first. Partial batches are never exposed to the reader.
- Bank FULL flag: set at the cycle the final write is issued (we = 1 for offset L-1). rd_valid therefore rises no earlier than the cycle after the last we.
- Read side: rd_valid = bank[rd_ptr] FULL; rd_bank = rd_ptr. rd_release while rd_valid = 1 marks that bank EMPTY and toggles rd_ptr. rd_release while rd_valid = 0 is ignored.
- Simultaneous events: fill completion and rd_release in the same cycle both take effect. If they target the same bank slot sequence, release applies to rd_ptr's bank and completion to fill_bank. WAIT_BANK exits the cycle after the release.
- Ordering: banks are delivered strictly in fill order (0, 1, 0, 1, ...).
- Reset asserted mid-operation: immediate return to the reset state. Bank contents are not cleared; flags mark them EMPTY.

Optional Feature:
FEATURE_CACHE_STALL_CNT_EN
- Defined: stall_count is a 16-bit saturating counter. It increments each cycle with data_ready = 1 and data_wanted = 0, and clears on reset only.
- Undefined: stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Single batch: enable = 1, batch_len = 4, data_ready held high with data 0xA0..0xA3 -> we on 4 consecutive cycles, waddr 0x000..0x003, wdata 0xA0..0xA3; rd_valid = 1, rd_bank = 0 one cycle after the last we.
- Ping-pong backpressure: batch_len = 2, reader never releases -> bank0 filled at waddr 0x000-0x001, bank1 at 0x400-0x401; then data_wanted = 0 in WAIT_BANK. rd_release -> rd_bank = 1; filling resumes at 0x000.
- Clamp: batch_len = 0 (ADDR_WIDTH = 3) -> 8 writes, waddr 0x0..0x7, then bank FULL.
- Mid-batch disable: batch_len = 4, enable dropped after 2 transfers -> 2 more transfers complete; FSM goes to IDLE; busy = 0; rd_valid = 1.
- Simultaneous completion and release: both banks in use, release rd_bank 0 in the same cycle as bank1's final write -> bank0 EMPTY, bank1 FULL, rd_bank = 1; no write lost.
- Async reset mid-fill and stall counter: assert resetn = 0 between clock edges -> all outputs 0 immediately. With FEATURE_CACHE_STALL_CNT_EN defined, 5 cycles of data_ready = 1 in WAIT_BANK -> stall_count = 5.
